// File: rtl/sap1_pkg.sv
// Shared SAP-1 loader definitions: bus widths, loader FSM states and the
// trailer checksum test used when LOADER_CHECKSUM_EN is defined.
package sap1_pkg;

  localparam int SAP1_ADDR_WIDTH = 4;
  localparam int SAP1_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_RECV  = 3'd1,
    LD_WRITE = 3'd2,
    LD_CHECK = 3'd3,
    LD_DONE  = 3'd4
  } loader_state_t;

  // A session is valid when the program bytes plus the trailer sum to zero mod 256.
  function automatic logic checksum_ok(input logic [7:0] sum, input logic [7:0] trailer);
    logic [7:0] total;
    total = sum + trailer;
    return (total == 8'd0);
  endfunction

endpackage

// File: rtl/sap1_program_loader_if.sv
// Byte-stream, RAM write port and status signals of the SAP-1 program loader.
// master = byte source / CPU top side, slave = loader.
interface sap1_program_loader_if
  import sap1_pkg::*;
#(
  parameter int ADDR_WIDTH = SAP1_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAP1_DATA_WIDTH
);
  logic                  load_req;
  logic                  abort;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output load_req, abort, in_valid, in_data,
    input  in_ready, ram_addr, ram_data, ram_we, cpu_hold, busy, done, error
  );

  modport slave (
    input  load_req, abort, in_valid, in_data,
    output in_ready, ram_addr, ram_data, ram_we, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/sap1_program_loader.sv
// Fills SAP-1 program RAM from a valid/ready byte stream while holding the CPU in reset.
// Optional trailer checksum stage enabled by defining LOADER_CHECKSUM_EN.
module sap1_program_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_WIDTH = SAP1_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAP1_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sap1_program_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  loader_state_t         r_state;
  loader_state_t         w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ram_we;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  w_hs;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_last;
  logic                  w_sum_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  // Next-state decode; abort outranks a same-cycle handshake.
  always_comb begin
    w_hs        = bus.in_valid && r_in_ready && !bus.abort;
    w_start     = bus.load_req && ((r_state == LD_IDLE) || (r_state == LD_DONE));
    w_abort     = bus.abort && ((r_state == LD_RECV) || (r_state == LD_WRITE) || (r_state == LD_CHECK));
    w_last      = (r_count == LAST_ADDR);
`ifdef LOADER_CHECKSUM_EN
    w_sum_ok    = checksum_ok(r_sum, 8'(bus.in_data));
`else
    w_sum_ok    = 1'b1;
`endif
    w_state_nxt = r_state;
    case (r_state)
      LD_IDLE, LD_DONE: begin
        if (w_start) w_state_nxt = LD_RECV;
        else         w_state_nxt = r_state;
      end
      LD_RECV: begin
        if (w_abort)   w_state_nxt = LD_IDLE;
        else if (w_hs) w_state_nxt = LD_WRITE;
        else           w_state_nxt = LD_RECV;
      end
      LD_WRITE: begin
        if (w_abort)     w_state_nxt = LD_IDLE;
`ifdef LOADER_CHECKSUM_EN
        else if (w_last) w_state_nxt = LD_CHECK;
`else
        else if (w_last) w_state_nxt = LD_DONE;
`endif
        else             w_state_nxt = LD_RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (w_abort)   w_state_nxt = LD_IDLE;
        else if (w_hs) w_state_nxt = LD_DONE;
        else           w_state_nxt = LD_CHECK;
      end
`endif
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  // State, counter and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= LD_IDLE;
      r_count    <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ram_we   <= (w_state_nxt == LD_WRITE);
      r_in_ready <= (w_state_nxt == LD_RECV) || (w_state_nxt == LD_CHECK);
      r_busy     <= (w_state_nxt == LD_RECV) || (w_state_nxt == LD_WRITE) ||
                    (w_state_nxt == LD_CHECK);
      if (w_start) begin
        r_count <= '0;
      end else if ((r_state == LD_WRITE) && !w_last) begin
        r_count <= r_count + ADDR_WIDTH'(1);
      end
      if ((r_state == LD_RECV) && w_hs) begin
        r_ram_data <= bus.in_data;
        r_ram_addr <= r_count;
      end
`ifdef LOADER_CHECKSUM_EN
      if (w_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else if (w_abort) begin
        r_error <= 1'b1;
      end else if ((r_state == LD_CHECK) && w_hs) begin
        r_done  <= w_sum_ok;
        r_error <= !w_sum_ok;
      end
`else
      if (w_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else if (w_abort) begin
        r_error <= 1'b1;
      end else if ((r_state == LD_WRITE) && w_last && w_sum_ok) begin
        r_done  <= 1'b1;
      end
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of the program bytes, cleared at each session start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= 8'd0;
    end else if (w_start) begin
      r_sum <= 8'd0;
    end else if ((r_state == LD_RECV) && w_hs) begin
      r_sum <= r_sum + 8'(bus.in_data);
    end
  end
`endif

  assign bus.in_ready = r_in_ready;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_data = r_ram_data;
  assign bus.ram_we   = r_ram_we;
  assign bus.cpu_hold = r_busy;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Scoreboard bench for sap1_program_loader: the stimulus side queues the expected RAM
// writes, a monitor checks every ram_we strobe against the queue and a RAM image.
module tb_sap1_program_loader;
  import sap1_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;
  int   wr_count = 0;
  int   tb_ram [DEPTH];
  wr_t  exp_q [$];
  int   wr_cycles [$];

  sap1_program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sap1_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (reset && bus.ram_we) begin
      wr_count++;
      wr_cycles.push_back(cycle);
      tb_ram[bus.ram_addr] = int'(bus.ram_data);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%02h, none expected", bus.ram_addr, bus.ram_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(bus.ram_addr), e.addr);
        chk("wr_data", int'(bus.ram_data), e.data);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_session(input string tag);
    bus.load_req = 1'b1;
    step();
    bus.load_req = 1'b0;
    chk({tag, "_start_busy"}, int'(bus.busy), 1);
    chk({tag, "_start_hold"}, int'(bus.cpu_hold), 1);
    chk({tag, "_start_done"}, int'(bus.done), 0);
    chk({tag, "_start_err"}, int'(bus.error), 0);
  endtask

  // Offer one byte, optionally after idle cycles; returns after the handshake edge.
  task automatic send_byte(input int idx, input logic [7:0] b, input int gap,
                           input bit expect_wr, output bit ok);
    int waited = 0;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 40) begin
      step();
      waited++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: byte %0d never accepted", idx);
      bus.in_valid = 1'b0;
      ok = 1'b0;
    end else begin
      if (expect_wr) exp_q.push_back('{idx, int'(b)});
      step();
      ok = 1'b1;
    end
  endtask

  // Called right after the final program byte's handshake edge.
  task automatic end_session(input logic [7:0] sum, input bit bad_trailer, input string tag);
    bit ok;
    logic [7:0] trailer;
`ifdef LOADER_CHECKSUM_EN
    trailer = (8'd0 - sum) ^ (bad_trailer ? 8'h01 : 8'h00);
    send_byte(DEPTH, trailer, 0, 1'b0, ok);
    bus.in_valid = 1'b0;
    step();
    chk({tag, "_done"}, int'(bus.done), bad_trailer ? 0 : 1);
    chk({tag, "_err"}, int'(bus.error), bad_trailer ? 1 : 0);
`else
    trailer = sum ^ {7'd0, bad_trailer};
    bus.in_valid = 1'b0;
    step();
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_err"}, int'(bus.error), 0);
`endif
    chk({tag, "_end_hold"}, int'(bus.cpu_hold), 0);
    chk({tag, "_end_busy"}, int'(bus.busy), 0);
    chk({tag, "_end_ready"}, int'(bus.in_ready), 0);
  endtask

  task automatic full_session(input logic [7:0] data [DEPTH], input int gap_max,
                              input bit bad_trailer, input string tag);
    bit ok;
    logic [7:0] sum = 8'd0;
    start_session(tag);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(i, data[i], int'($urandom_range(0, gap_max)), 1'b1, ok);
      sum = sum + data[i];
      if (!ok) break;
    end
    end_session(sum, bad_trailer, tag);
    for (int i = 0; i < DEPTH; i++) chk({tag, "_ram"}, tb_ram[i], int'(data[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] data [DEPTH];
    bit ok;
    int wc;
    int k;
    logic [7:0] sum;

    foreach (tb_ram[i]) tb_ram[i] = -1;
    bus.load_req = 1'b0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    repeat (2) step();
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_we", int'(bus.ram_we), 0);
    chk("rst_hold", int'(bus.cpu_hold), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.error), 0);
    chk("rst_addr", int'(bus.ram_addr), 0);
    chk("rst_data", int'(bus.ram_data), 0);
    reset = 1'b1;
    step();
    chk("idle_busy", int'(bus.busy), 0);

    // Reset mid-session after 3 bytes, with byte 3 on offer
    start_session("rstmid");
    for (int i = 0; i < 3; i++) send_byte(i, 8'hA0 + 8'(i), 0, 1'b1, ok);
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA3;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ready", int'(bus.in_ready), 0);
    chk("arst_hold", int'(bus.cpu_hold), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_addr", int'(bus.ram_addr), 0);
    chk("arst_data", int'(bus.ram_data), 0);
    bus.in_valid = 1'b0;
    repeat (2) step();
    chk("arst_wr_count", wr_count, 3);
    for (int i = 0; i < 3; i++) chk("arst_ram_kept", tb_ram[i], 'hA0 + i);
    chk("arst_ram3_unwritten", tb_ram[3], -1);
    reset = 1'b1;
    step();

    // Full load, in_valid held high: writes every 2 cycles, then DONE
    for (int i = 0; i < DEPTH; i++) data[i] = 8'h1E + 8'(i * 17);
    wr_cycles.delete();
    full_session(data, 0, 1'b0, "full");
    chk("full_wr_total", wr_cycles.size(), DEPTH);
    for (int i = 1; i < wr_cycles.size(); i++)
      chk("full_wr_interval", wr_cycles[i] - wr_cycles[i-1], 2);
    wc = wr_count;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) begin
      step();
      chk("done_no_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    chk("done_no_extra_wr", wr_count, wc);

    // Stalled source between bytes 4 and 5
    for (int i = 0; i < DEPTH; i++) data[i] = 8'($urandom);
    sum = 8'd0;
    start_session("stall");
    for (int i = 0; i < 4; i++) begin
      send_byte(i, data[i], 0, 1'b1, ok);
      sum = sum + data[i];
    end
    bus.in_valid = 1'b0;
    step();
    wc = wr_count;
    repeat (5) begin
      step();
      chk("stall_ready", int'(bus.in_ready), 1);
      chk("stall_we", int'(bus.ram_we), 0);
    end
    chk("stall_no_wr", wr_count, wc);
    for (int i = 4; i < DEPTH; i++) begin
      send_byte(i, data[i], 0, 1'b1, ok);
      sum = sum + data[i];
    end
    end_session(sum, 1'b0, "stall");
    for (int i = 0; i < DEPTH; i++) chk("stall_ram", tb_ram[i], int'(data[i]));

    // Abort at byte 7 while in RECV, with a competing handshake
    start_session("abort");
    for (int i = 0; i < 7; i++) send_byte(i, 8'hC0 + 8'(i), 0, 1'b1, ok);
    bus.in_valid = 1'b0;
    step();
    wc = wr_count;
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_err", int'(bus.error), 1);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_hold", int'(bus.cpu_hold), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ready", int'(bus.in_ready), 0);
    bus.abort = 1'b1;
    repeat (3) step();
    bus.abort = 1'b0;
    chk("abort_no_wr", wr_count, wc);
    chk("abort_idle_err_kept", int'(bus.error), 1);
    for (int i = 0; i < DEPTH; i++) data[i] = 8'($urandom);
    full_session(data, 2, 1'b0, "restart");

    // Abort during WRITE at a random position
    repeat (2) begin
      k = int'($urandom_range(1, DEPTH - 2));
      start_session("abw");
      for (int i = 0; i < k; i++) send_byte(i, 8'($urandom), 1, 1'b1, ok);
      bus.in_valid = 1'b0;
      chk("abw_in_write", int'(bus.ram_we), 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      wc = wr_count;
      chk("abw_err", int'(bus.error), 1);
      chk("abw_busy", int'(bus.busy), 0);
      repeat (3) step();
      chk("abw_no_wr", wr_count, wc);
    end

    // Random sessions with random source gaps
    repeat (3) begin
      for (int i = 0; i < DEPTH; i++) data[i] = 8'($urandom);
      full_session(data, 3, 1'b0, "rand");
    end

`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < DEPTH; i++) data[i] = 8'h01;
    full_session(data, 0, 1'b0, "csum_good");
    full_session(data, 0, 1'b1, "csum_bad");
`endif

    repeat (2) step();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
